pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Holds the architectural PC and fetches one 32-bit instruction per PC from instruction memory over a valid/ready request/response handshake. Sits between the next-PC generator and decode. It presents the fetched instruction and its PC to decode and, when decode accepts the instruction, loads the next-PC value computed for that instruction. It flags misaligned targets and memory errors as a sticky fault.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: PC loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `next_pc`  in  64  next-PC generator output for the instruction currently in HOLD; bit 0 is already zero.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  64  fetch address (= `pc`).
- `imem_rsp_valid`  in  1  response valid; one-cycle pulse.
- `imem_rsp_data`  in  32  fetched instruction.
- `imem_rsp_err`  in  1  access error, qualified by `imem_rsp_valid`.
- `inst_valid`  out  1  instruction available to decode.
- `inst_ready`  in  1  decode consumes the instruction this cycle.
- `inst`  out  32  held instruction.
- `pc`  out  64  current PC; fed to the next-PC generator and decode.
- `fault`  out  1  sticky fault flag.
- `fetch_count`  out  64  number of instructions accepted by decode.

## Operation
- States: REQ, WAIT, HOLD, FAULT.
- **REQ**
  - `imem_req_valid`=1 and `imem_addr`=`pc`.
  - When `imem_req_ready`=1, go to WAIT.
- **WAIT**
  - No request is issued.
  - When `imem_rsp_valid`=1 and `imem_rsp_err`=0: latch `imem_rsp_data` into `inst` and go to HOLD.
  - When `imem_rsp_valid`=1 and `imem_rsp_err`=1: go to FAULT; `inst` is unchanged.
- **HOLD**
  - `inst_valid`=1.
  - When `inst_ready`=1: `pc` <= `next_pc`, `fetch_count` += 1.
  - After that update, if `next_pc[1]`=1 go to FAULT, otherwise go to REQ.
- **FAULT**
  - `fault`=1; all valids are 0; no state changes except by reset.
  - `pc` keeps the offending target (or the failing address on `imem_rsp_err`).
- `imem_rsp_valid` outside WAIT is ignored; no data is latched.
- `inst_ready` outside HOLD is ignored.
- `fetch_count` is modulo 2^64 and wraps to 0.
- Encoding uses 2 bits: REQ=0, WAIT=1, HOLD=2, FAULT=3.

## Timing
- **Reset** (asynchronous, immediate on `rst`):
  - state=REQ, `pc`=`RESET_PC`, `inst`=0, `fetch_count`=0, `fault`=0.
  - Because state=REQ, `imem_req_valid`=1 during reset and on the first cycle after release.
- `imem_req_valid`, `inst_valid` and `fault` are decoded from the registered state only, so they are glitch-free.
- `imem_addr`, `pc` and `inst` are register outputs.
- `imem_addr` is stable while `imem_req_valid` && !`imem_req_ready`. The request is never withdrawn before acceptance.
- **Minimum latency per instruction: 3 cycles.**
  - Cycle N: REQ, request accepted.
  - Cycle N+1: WAIT, response arrives.
  - Cycle N+2: HOLD, decode accepts.
  - Cycle N+3: REQ for the new PC.
- A response in the same cycle as request acceptance is not legal and is ignored. The earliest response is the cycle after acceptance.
- `next_pc` is sampled only in the HOLD cycle in which `inst_ready`=1.
- Reset asserted in any state (including mid-WAIT) aborts the transaction. A late response arriving after reset is ignored because the state is REQ.

## Structure
- Shared header `npc_defs`:
  - state encoding localparams `IFU_REQ`, `IFU_WAIT`, `IFU_HOLD`, `IFU_FAULT`;
  - default `RESET_PC`;
  - `INST_W`=32 and `XLEN`=64.
- One sub-module, `ifu_fsm`, covers the state register and next-state logic. Its inputs are the handshake and fault conditions; it outputs the state.
- The top level holds `pc`, `inst`, `fetch_count` and the output decode.

## Test plan
- **Reset fetch**: release `rst`, `imem_req_ready`=1, respond 32'h00000013 one cycle later, `inst_ready`=1.
  - Expect `imem_addr`=64'h80000000.
  - Expect `inst`=32'h00000013 with `inst_valid` at cycle 2.
  - Expect `pc`=`next_pc` (64'h80000004) and `fetch_count`=1 at cycle 3.
- **Backpressure**: hold `imem_req_ready`=0 for 4 cycles, then 1; hold `inst_ready`=0 for 3 cycles in HOLD.
  - Expect `imem_addr` and `inst` stable throughout.
  - Expect exactly one PC update.
- **Jump**: in HOLD drive `next_pc`=64'h80001000 with `inst_ready`=1.
  - Expect the next `imem_addr`=64'h80001000.
- **Misaligned target**: `next_pc`=64'h80000006 accepted.
  - Expect `fault`=1 the next cycle and `pc`=64'h80000006.
  - Expect no further requests, even with `imem_req_ready`=1 for 10 cycles.
- **Memory error**: `imem_rsp_err`=1 with `imem_rsp_valid` in WAIT.
  - Expect FAULT, `inst_valid` never 1, and `fetch_count` unchanged.
- **Mid-transaction reset and spurious response**: assert `rst` in WAIT, then deliver `imem_rsp_valid` right after release.
  - Expect the response ignored and `pc`=`RESET_PC`.
  - Expect a fresh request at 64'h80000000.

Source files
------------

// File: rtl/npc_defs.sv
// Shared definitions for the PC fetch unit: widths, reset PC, FSM encoding
// and a small helper that classifies a fetch target.
package npc_defs;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    localparam logic [1:0] IFU_REQ   = 2'd0;
    localparam logic [1:0] IFU_WAIT  = 2'd1;
    localparam logic [1:0] IFU_HOLD  = 2'd2;
    localparam logic [1:0] IFU_FAULT = 2'd3;

    typedef enum logic [1:0] {
        ST_REQ   = IFU_REQ,
        ST_WAIT  = IFU_WAIT,
        ST_HOLD  = IFU_HOLD,
        ST_FAULT = IFU_FAULT
    } ifu_state_t;

    // Instructions are 4-byte aligned; bit 0 is already cleared by the
    // next-PC generator, so only bit 1 can make a target illegal.
    function automatic logic target_misaligned(input logic [XLEN-1:0] target);
        return target[1];
    endfunction

endpackage

// File: rtl/ifu_fsm.sv
// Fetch sequencing FSM: request -> wait for response -> hold for decode,
// with a terminal fault state left only through reset.
module ifu_fsm
    import npc_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_ready,
    input  logic       rsp_valid,
    input  logic       rsp_err,
    input  logic       inst_ready,
    input  logic       bad_target,
    output ifu_state_t state
);

    ifu_state_t state_next;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; inputs not relevant to the current state are ignored.
    always_comb begin
        state_next = state;
        case (state)
            ST_REQ: begin
                if (req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rsp_valid) begin
                    state_next = rsp_err ? ST_FAULT : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    state_next = bad_target ? ST_FAULT : ST_REQ;
                end
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: holds the architectural PC, fetches one instruction per PC
// over a valid/ready memory handshake and hands it to decode.
module pc_fetch_unit
    import npc_defs::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] next_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] pc,
    output logic        fault,
    output logic [63:0] fetch_count
);

    ifu_state_t state;
    logic       accept;
    logic       rsp_good;

    // Decode takes the held instruction; this is the only point where the
    // PC advances and next_pc is looked at.
    assign accept   = (state == ST_HOLD) && inst_ready;
    // Responses count only while a request is outstanding.
    assign rsp_good = (state == ST_WAIT) && imem_rsp_valid && !imem_rsp_err;

    ifu_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .req_ready  (imem_req_ready),
        .rsp_valid  (imem_rsp_valid),
        .rsp_err    (imem_rsp_err),
        .inst_ready (inst_ready),
        .bad_target (target_misaligned(next_pc)),
        .state      (state)
    );

    // PC register; a misaligned target is still loaded so the fault reports it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (accept) begin
            pc <= next_pc;
        end
    end

    // Instruction holding register; an error response leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst <= '0;
        end else if (rsp_good) begin
            inst <= imem_rsp_data;
        end
    end

    // Count of instructions accepted by decode; wraps naturally at 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (accept) begin
            fetch_count <= fetch_count + 64'd1;
        end
    end

    // Handshake outputs decode purely from the registered state.
    assign imem_req_valid = (state == ST_REQ);
    assign imem_addr      = pc;
    assign inst_valid     = (state == ST_HOLD);
    assign fault          = (state == ST_FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] next_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
    logic [63:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Transaction-level model: where the current fetch is in its life.
    bit          m_need_req;   // request not yet accepted
    bit          m_in_flight;  // accepted, awaiting response
    bit          m_have_inst;  // instruction waiting for decode
    bit          m_dead;       // faulted, waits for reset
    logic [63:0] m_pc;
    logic [31:0] m_inst;
    logic [63:0] m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_need_req  <= 1'b1;
            m_in_flight <= 1'b0;
            m_have_inst <= 1'b0;
            m_dead      <= 1'b0;
            m_pc        <= RST_PC;
            m_inst      <= '0;
            m_cnt       <= '0;
        end else if (m_need_req) begin
            if (imem_req_ready) begin
                m_need_req  <= 1'b0;
                m_in_flight <= 1'b1;
            end
        end else if (m_in_flight) begin
            if (imem_rsp_valid) begin
                m_in_flight <= 1'b0;
                if (imem_rsp_err) begin
                    m_dead <= 1'b1;
                end else begin
                    m_inst      <= imem_rsp_data;
                    m_have_inst <= 1'b1;
                end
            end
        end else if (m_have_inst) begin
            if (inst_ready) begin
                m_have_inst <= 1'b0;
                m_pc        <= next_pc;
                m_cnt       <= m_cnt + 64'd1;
                if (next_pc % 4 != 0) m_dead <= 1'b1;
                else                  m_need_req <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("req_valid",   {63'd0, imem_req_valid}, {63'd0, m_need_req});
        chk("imem_addr",   imem_addr,               m_pc);
        chk("inst_valid",  {63'd0, inst_valid},     {63'd0, m_have_inst});
        chk("inst",        {32'd0, inst},           {32'd0, m_inst});
        chk("pc",          pc,                      m_pc);
        chk("fault",       {63'd0, fault},          {63'd0, m_dead});
        chk("fetch_count", fetch_count,             m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // One complete fetch at minimum latency, ending back in REQ (or FAULT).
    task automatic fetch(input logic [31:0] data, input logic [63:0] npc);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b1;
        next_pc        = npc;
        step();
        inst_ready     = 1'b0;
    endtask

    initial begin
        // Reset fetch
        step();
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("rst_pc", pc, 64'h80000000);
        chk("rst_count", fetch_count, 64'd0);
        rst = 1'b0;
        chk("first_addr", imem_addr, 64'h80000000);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00000013;
        step();
        imem_rsp_valid = 1'b0;
        chk("first_inst", {32'd0, inst}, 64'h13);
        chk("first_inst_valid", {63'd0, inst_valid}, 64'd1);
        inst_ready = 1'b1;
        next_pc    = 64'h80000004;
        step();
        inst_ready = 1'b0;
        chk("first_pc_update", pc, 64'h80000004);
        chk("first_count", fetch_count, 64'd1);

        // Backpressure on both sides
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_addr_stable", imem_addr, 64'h80000004);
            chk("bp_req_held", {63'd0, imem_req_valid}, 64'd1);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEADBEEF;
        step();
        imem_rsp_valid = 1'b0;
        next_pc = 64'h80000008;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_inst_stable", {32'd0, inst}, 64'hDEADBEEF);
            chk("bp_pc_stable", pc, 64'h80000004);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("bp_pc_once", pc, 64'h80000008);
        chk("bp_count", fetch_count, 64'd2);

        // Jump
        fetch(32'h0000006F, 64'h80001000);
        chk("jump_addr", imem_addr, 64'h80001000);
        chk("jump_req", {63'd0, imem_req_valid}, 64'd1);

        // Misaligned target
        fetch(32'h00000067, 64'h80000006);
        chk("mis_fault", {63'd0, fault}, 64'd1);
        chk("mis_pc", pc, 64'h80000006);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mis_no_req", {63'd0, imem_req_valid}, 64'd0);
        end
        imem_req_ready = 1'b0;
        chk("mis_count", fetch_count, 64'd4);

        // Memory error
        do_reset();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        imem_rsp_data  = 32'h12345678;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("err_fault", {63'd0, fault}, 64'd1);
            chk("err_no_inst_valid", {63'd0, inst_valid}, 64'd0);
            step();
        end
        chk("err_inst_kept", {32'd0, inst}, 64'd0);
        chk("err_count", fetch_count, 64'd0);
        chk("err_pc", pc, 64'h80000000);

        // Mid-transaction reset followed by a stray response
        do_reset();
        fetch(32'h00000013, 64'h80000010);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_pc", pc, RST_PC);
        step();
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFEF00D;
        step();
        imem_rsp_valid = 1'b0;
        chk("stray_ignored_inst", {32'd0, inst}, 64'd0);
        chk("stray_no_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("fresh_req", {63'd0, imem_req_valid}, 64'd1);
        chk("fresh_addr", imem_addr, 64'h80000000);

        // Randomized traffic, judged by the per-cycle model comparison
        for (int c = 0; c < 4000; c++) begin
            imem_req_ready = ($urandom_range(0, 2) != 0);
            imem_rsp_valid = ($urandom_range(0, 2) == 0);
            imem_rsp_err   = ($urandom_range(0, 39) == 0);
            imem_rsp_data  = $urandom;
            inst_ready     = $urandom_range(0, 1) == 1;
            next_pc        = {$urandom, $urandom};
            next_pc[0]     = 1'b0;
            next_pc[1]     = ($urandom_range(0, 29) == 0);
            if ((m_dead && $urandom_range(0, 4) == 0) || $urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
